// File: rtl/execute_mem_ctrl.sv
// RV32I execute stage: ALU/branch results in one cycle, loads and stores through a
// single-outstanding system bus with optional read timeout. All outputs are registered.
module execute_mem_ctrl #(
  parameter int BUS_ADDR_WIDTH = 30,
  parameter int READ_TIMEOUT   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // instruction handshake: an instruction transfers on a cycle where enable && ready
  input  logic                      enable,
  output logic                      ready,
  input  logic [31:0]               pc_value,
  input  logic [31:0]               instruction,
  input  logic [31:0]               register_file_read_data1,
  input  logic [31:0]               register_file_read_data2,
  output logic                      result_valid,
  output logic [4:0]                rd,
  output logic [31:0]               next_pc,
  output logic                      rd_value_write_enable,
  output logic [31:0]               rd_value_write_data,
  output logic                      trap,
  input  logic                      system_bus_ready,
  output logic [BUS_ADDR_WIDTH-1:0] system_bus_addr,
  output logic [3:0]                system_bus_byte_enable,
  output logic                      system_bus_read_req,
  output logic                      system_bus_write_req,
  output logic [31:0]               system_bus_write_data,
  input  logic [31:0]               system_bus_read_data,
  input  logic                      system_bus_read_data_valid,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS_REQ = 2'd1, READ_WAIT = 2'd2} state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int CW = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT + 1) : 1;

  state_t state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [31:0]               pc_q, pc_d;
  logic [2:0]                f3_q, f3_d;
  logic [4:0]                rdf_q, rdf_d;
  logic [1:0]                alo_q, alo_d;
  logic                      rv_q, rv_d;
  logic [4:0]                rd_q, rd_d;
  logic [31:0]               npc_q, npc_d;
  logic                      wen_q, wen_d;
  logic [31:0]               wd_q, wd_d;
  logic                      trap_q, trap_d;
  logic [BUS_ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               bwd_q, bwd_d;
  logic                      rreq_q, rreq_d;
  logic                      wreq_q, wreq_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_field;
  logic [31:0] rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] mem_addr, pc_plus4, nm_wd, nm_npc, st_wd, lane, load_val;
  logic [3:0]  st_be;
  logic        is_load, is_store, is_mem, misaligned, accept, nm_wen, timeout_hit;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign rd_field = instruction[11:7];
  assign rs1      = register_file_read_data1;
  assign rs2      = register_file_read_data2;
  assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u    = {instruction[31:12], 12'd0};
  assign imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
  assign pc_plus4 = pc_value + 32'd4;
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign mem_addr = rs1 + (is_store ? imm_s : imm_i);
  assign accept   = enable && (state_q == IDLE);

  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr[0];
      default: misaligned = |mem_addr[1:0];
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_be = 4'b0001 << mem_addr[1:0];
        st_wd = {4{rs2[7:0]}};
      end
      2'b01: begin
        st_be = 4'b0011 << mem_addr[1:0];
        st_wd = {2{rs2[15:0]}};
      end
      default: begin
        st_be = 4'hF;
        st_wd = rs2;
      end
    endcase
  end

  always_comb begin
    nm_wd  = 32'd0;
    nm_npc = pc_plus4;
    nm_wen = 1'b0;
    case (opcode)
      OPC_OP: begin
        nm_wd  = alu(funct3, instruction[30], rs1, rs2);
        nm_wen = 1'b1;
      end
      OPC_OPIMM: begin
        nm_wd  = alu(funct3, (funct3 == 3'b101) && instruction[30], rs1, imm_i);
        nm_wen = 1'b1;
      end
      OPC_LUI: begin
        nm_wd  = imm_u;
        nm_wen = 1'b1;
      end
      OPC_AUIPC: begin
        nm_wd  = pc_value + imm_u;
        nm_wen = 1'b1;
      end
      OPC_JAL: begin
        nm_wd  = pc_plus4;
        nm_npc = pc_value + imm_j;
        nm_wen = 1'b1;
      end
      OPC_JALR: begin
        nm_wd  = pc_plus4;
        nm_npc = (rs1 + imm_i) & ~32'd1;
        nm_wen = 1'b1;
      end
      OPC_BRANCH: begin
        if (branch_taken(funct3, rs1, rs2)) nm_npc = pc_value + imm_b;
      end
      default: ;
    endcase
    if (rd_field == 5'd0) nm_wen = 1'b0;
  end

  always_comb begin
    lane = system_bus_read_data >> {alo_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = system_bus_read_data;
    endcase
  end

  assign timeout_hit = (READ_TIMEOUT > 0) && ((int'(cnt_q) + 1) >= READ_TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      f3_q    <= '0;
      rdf_q   <= '0;
      alo_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      npc_q   <= '0;
      wen_q   <= 1'b0;
      wd_q    <= '0;
      trap_q  <= 1'b0;
      baddr_q <= '0;
      be_q    <= '0;
      bwd_q   <= '0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      f3_q    <= f3_d;
      rdf_q   <= rdf_d;
      alo_q   <= alo_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      npc_q   <= npc_d;
      wen_q   <= wen_d;
      wd_q    <= wd_d;
      trap_q  <= trap_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      bwd_q   <= bwd_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_mem && !misaligned) state_d = BUS_REQ;
      BUS_REQ:   if (system_bus_ready) state_d = wreq_q ? IDLE : READ_WAIT;
      READ_WAIT: if (system_bus_read_data_valid || timeout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    f3_d    = f3_q;
    rdf_d   = rdf_q;
    alo_d   = alo_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    npc_d   = npc_q;
    wen_d   = wen_q;
    wd_d    = wd_q;
    trap_d  = trap_q;
    baddr_d = baddr_q;
    be_d    = be_q;
    bwd_d   = bwd_q;
    rreq_d  = rreq_q;
    wreq_d  = wreq_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pc_d  = pc_value;
          f3_d  = funct3;
          rdf_d = rd_field;
          alo_d = mem_addr[1:0];
          if (is_mem && !misaligned) begin
            baddr_d = mem_addr[BUS_ADDR_WIDTH+1:2];
            be_d    = is_store ? st_be : 4'hF;
            if (is_store) bwd_d = st_wd;
            rreq_d  = is_load;
            wreq_d  = is_store;
          end else begin
            rv_d   = 1'b1;
            rd_d   = rd_field;
            npc_d  = (is_mem) ? pc_plus4 : nm_npc;
            wen_d  = (is_mem) ? 1'b0 : nm_wen;
            wd_d   = (is_mem) ? 32'd0 : nm_wd;
            trap_d = is_mem;
          end
        end
      end
      BUS_REQ: begin
        if (system_bus_ready) begin
          rreq_d = 1'b0;
          wreq_d = 1'b0;
          cnt_d  = '0;
          if (wreq_q) begin
            rv_d   = 1'b1;
            rd_d   = rdf_q;
            npc_d  = pc_q + 32'd4;
            wen_d  = 1'b0;
            wd_d   = 32'd0;
            trap_d = 1'b0;
          end
        end
      end
      READ_WAIT: begin
        if (system_bus_read_data_valid || timeout_hit) begin
          rv_d   = 1'b1;
          rd_d   = rdf_q;
          npc_d  = pc_q + 32'd4;
          trap_d = !system_bus_read_data_valid;
          wen_d  = system_bus_read_data_valid && (rdf_q != 5'd0);
          wd_d   = system_bus_read_data_valid ? load_val : 32'd0;
        end
        // saturate so a long wait never wraps back below the limit
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  assign ready                  = (state_q == IDLE);
  assign result_valid           = rv_q;
  assign rd                     = rd_q;
  assign next_pc                = npc_q;
  assign rd_value_write_enable  = wen_q;
  assign rd_value_write_data    = wd_q;
  assign trap                   = trap_q;
  assign system_bus_addr        = baddr_q;
  assign system_bus_byte_enable = be_q;
  assign system_bus_read_req    = rreq_q;
  assign system_bus_write_req   = wreq_q;
  assign system_bus_write_data  = bwd_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_execute_mem_ctrl.sv
// Directed and random instruction stream against an ISA-level reference model,
// with a bus responder driving random acceptance and read-data latency.
module tb_execute_mem_ctrl;
  localparam int AW = 30;
  localparam int TO = 4;
  localparam int W  = 71;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable, ready;
  logic [31:0]   pc_value, instruction, rs1_val, rs2_val;
  logic          result_valid, rd_value_write_enable, trap;
  logic [4:0]    rd;
  logic [31:0]   next_pc, rd_value_write_data;
  logic          system_bus_ready, system_bus_read_req, system_bus_write_req;
  logic [AW-1:0] system_bus_addr;
  logic [3:0]    system_bus_byte_enable;
  logic [31:0]   system_bus_write_data, system_bus_read_data;
  logic          system_bus_read_data_valid;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int          bus;  // 0 none, 1 read, 2 write
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        trap, wen;
    logic [4:0]  rd;
    logic [31:0] npc, wd;
    logic        chk_npc, chk_wd;
  } exp_t;

  execute_mem_ctrl #(.BUS_ADDR_WIDTH(AW), .READ_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ready(ready),
    .pc_value(pc_value), .instruction(instruction),
    .register_file_read_data1(rs1_val), .register_file_read_data2(rs2_val),
    .result_valid(result_valid), .rd(rd), .next_pc(next_pc),
    .rd_value_write_enable(rd_value_write_enable), .rd_value_write_data(rd_value_write_data),
    .trap(trap), .system_bus_ready(system_bus_ready), .system_bus_addr(system_bus_addr),
    .system_bus_byte_enable(system_bus_byte_enable), .system_bus_read_req(system_bus_read_req),
    .system_bus_write_req(system_bus_write_req), .system_bus_write_data(system_bus_write_data),
    .system_bus_read_data(system_bus_read_data),
    .system_bus_read_data_valid(system_bus_read_data_valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ISA-level reference: what the instruction means, independent of pipeline timing
  function automatic exp_t ref_exec(input logic [31:0] pc, input logic [31:0] ins,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] rdata, input bit no_data);
    exp_t e;
    logic [31:0] ii, is, ib, iu, ij, ea, v;
    logic [2:0] f3;
    int off;
    e = '{default: 0};
    f3 = ins[14:12];
    e.rd = ins[11:7];
    e.npc = pc + 4;
    e.chk_npc = 1'b1;
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h33, 7'h13: begin
        v = (ins[6:0] == 7'h33) ? b : ii;
        case (f3)
          0: e.wd = (ins[6:0] == 7'h33 && ins[30]) ? a - v : a + v;
          1: e.wd = a << v[4:0];
          2: e.wd = ($signed(a) < $signed(v)) ? 1 : 0;
          3: e.wd = (a < v) ? 1 : 0;
          4: e.wd = a ^ v;
          5: e.wd = ins[30] ? 32'($signed(a) >>> v[4:0]) : a >> v[4:0];
          6: e.wd = a | v;
          default: e.wd = a & v;
        endcase
        e.wen = 1'b1;
      end
      7'h37: begin e.wd = iu; e.wen = 1'b1; end
      7'h17: begin e.wd = pc + iu; e.wen = 1'b1; end
      7'h6F: begin e.wd = pc + 4; e.npc = pc + ij; e.wen = 1'b1; end
      7'h67: begin e.wd = pc + 4; e.npc = (a + ii) & 32'hFFFF_FFFE; e.wen = 1'b1; end
      7'h63: begin
        case (f3)
          0: if (a == b) e.npc = pc + ib;
          1: if (a != b) e.npc = pc + ib;
          4: if ($signed(a) < $signed(b)) e.npc = pc + ib;
          5: if ($signed(a) >= $signed(b)) e.npc = pc + ib;
          6: if (a < b) e.npc = pc + ib;
          7: if (a >= b) e.npc = pc + ib;
          default: ;
        endcase
      end
      7'h03, 7'h23: begin
        ea = a + ((ins[6:0] == 7'h23) ? is : ii);
        off = int'(ea[1:0]);
        if ((f3[1:0] == 2'b01 && off % 2 != 0) || (f3[1:0] >= 2'b10 && off != 0)) begin
          e.trap = 1'b1;
          e.chk_npc = 1'b0;
        end else if (ins[6:0] == 7'h23) begin
          e.bus = 2;
          e.addr = ea;
          if (f3[1:0] == 2'b00) begin e.be = 4'b0001 << off; e.bwd = {4{b[7:0]}}; end
          else if (f3[1:0] == 2'b01) begin e.be = 4'b0011 << off; e.bwd = {2{b[15:0]}}; end
          else begin e.be = 4'hF; e.bwd = b; end
        end else begin
          e.bus = 1;
          e.addr = ea;
          e.be = 4'hF;
          if (no_data) e.trap = 1'b1;
          else begin
            v = rdata >> (8 * off);
            case (f3)
              0: e.wd = 32'($signed(v[7:0]));
              1: e.wd = 32'($signed(v[15:0]));
              4: e.wd = {24'd0, v[7:0]};
              5: e.wd = {16'd0, v[15:0]};
              default: e.wd = rdata;
            endcase
            e.wen = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (e.rd == 5'd0) e.wen = 1'b0;
    e.chk_wd = e.wen;
    return e;
  endfunction

  // rd_lat < 0 means the read data never arrives
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input int bus_lat, input int rd_lat,
                           input logic [31:0] rdata);
    exp_t e;
    logic [W-1:0] pk;
    e = ref_exec(pc, ins, a, b, rdata, rd_lat < 0);
    exp_q.push_back({e.trap, e.wen, e.rd, e.npc, e.wd});
    @(negedge clk);
    check("ready_idle", ready, 1);
    enable = 1'b1; pc_value = pc; instruction = ins; rs1_val = a; rs2_val = b;
    system_bus_read_data_valid = 1'($urandom_range(0, 1));
    system_bus_read_data = $urandom;
    @(negedge clk);
    enable = 1'b0; pc_value = $urandom; instruction = $urandom;
    rs1_val = $urandom; rs2_val = $urandom;
    system_bus_read_data_valid = 1'b0;
    if (e.bus != 0) begin
      for (int i = 0; i <= bus_lat; i++) begin
        check("bus_req", {system_bus_read_req, system_bus_write_req}, (e.bus == 1) ? 2'b10 : 2'b01);
        check("bus_addr", system_bus_addr, e.addr[AW+1:2]);
        check("bus_be", system_bus_byte_enable, e.be);
        if (e.bus == 2) check("bus_wdata", system_bus_write_data, e.bwd);
        check("ready_busy", ready, 0);
        system_bus_ready = (i == bus_lat);
        system_bus_read_data_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      system_bus_ready = 1'b0;
      system_bus_read_data_valid = 1'b0;
      if (e.bus == 1) begin
        if (rd_lat < 0) begin
          for (int k = 0; k < TO; k++) begin
            check("rw_wait_to", result_valid, 0);
            check("rw_ready", ready, 0);
            @(negedge clk);
          end
        end else begin
          for (int k = 0; k <= rd_lat; k++) begin
            check("rw_wait", result_valid, 0);
            check("rw_noreq", {system_bus_read_req, system_bus_write_req}, 0);
            system_bus_read_data_valid = (k == rd_lat);
            system_bus_read_data = (k == rd_lat) ? rdata : $urandom;
            @(negedge clk);
          end
          system_bus_read_data_valid = 1'b0;
        end
      end
    end
    pk = exp_q.pop_front();
    check("result_valid", result_valid, 1);
    check("res_trap", trap, pk[70]);
    check("res_wen", rd_value_write_enable, pk[69]);
    if (e.wen) check("res_rd", rd, pk[68:64]);
    if (e.chk_npc) check("res_npc", next_pc, pk[63:32]);
    if (e.chk_wd) check("res_wdata", rd_value_write_data, pk[31:0]);
    check("res_noreq", {system_bus_read_req, system_bus_write_req}, 0);
    check("res_ready", ready, 1);
    @(negedge clk);
    check("pulse_end", result_valid, 0);
    check("hold_trap", trap, pk[70]);
    if (e.chk_npc) check("hold_npc", next_pc, pk[63:32]);
    if (e.chk_wd) check("hold_wdata", rd_value_write_data, pk[31:0]);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rdf, input logic [6:0] op);
    return {imm, 5'd1, f3, rdf, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  initial begin
    logic [31:0] ins, a, b;
    logic [2:0] f3;
    logic [2:0] br_f3[6];
    logic [2:0] ld_f3[5];
    bit alt;
    int cls, rl;
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset_n = 1'b0; enable = 1'b0; pc_value = '0; instruction = '0;
    rs1_val = '0; rs2_val = '0; system_bus_ready = 1'b0;
    system_bus_read_data = '0; system_bus_read_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rv", result_valid, 0);
    check("rst_trap", trap, 0);
    check("rst_wen", rd_value_write_enable, 0);
    check("rst_req", {system_bus_read_req, system_bus_write_req}, 0);
    check("rst_rd_npc_wd", {rd, next_pc, rd_value_write_data}, 0);
    check("rst_bus", {system_bus_addr, system_bus_byte_enable, system_bus_write_data}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);

    // ADDI x5,x0,-1
    run_instr(32'h200, enc_i(12'hFFF, 3'd0, 5'd5, 7'h13), 32'd0, 32'd0, 0, 0, 32'd0);
    // SB with slow bus acceptance
    run_instr(32'h204, enc_s(12'd0, 3'd0), 32'h1001, 32'hA5, 3, 0, 32'd0);
    // LH / LHU upper half
    run_instr(32'h208, enc_i(12'd2, 3'd1, 5'd7, 7'h03), 32'h100, 32'd0, 1, 1, 32'h8001_0000);
    run_instr(32'h20C, enc_i(12'd2, 3'd5, 5'd7, 7'h03), 32'h100, 32'd0, 0, 0, 32'h8001_0000);
    // misaligned LW traps without touching the bus
    run_instr(32'h210, enc_i(12'd2, 3'd2, 5'd8, 7'h03), 32'h4, 32'd0, 0, 0, 32'd0);
    // read timeout
    run_instr(32'h214, enc_i(12'd0, 3'd2, 5'd9, 7'h03), 32'h40, 32'd0, 2, -1, 32'd0);
    // taken BEQ, offset -8
    run_instr(32'h100, enc_b(13'h1FF8, 3'd0), 32'd7, 32'd7, 0, 0, 32'd0);
    // SH upper half, LB sign, LW to x0
    run_instr(32'h300, enc_s(12'd6, 3'd1), 32'h1000, 32'h1234_BEEF, 0, 0, 32'd0);
    run_instr(32'h304, enc_i(12'd3, 3'd0, 5'd4, 7'h03), 32'h1000, 32'd0, 0, 2, 32'h80FF_FFFF);
    run_instr(32'h308, enc_i(12'd0, 3'd2, 5'd0, 7'h03), 32'h2000, 32'd0, 1, 0, 32'hCAFE_F00D);

    // reset in READ_WAIT abandons the load; late data is ignored
    @(negedge clk);
    enable = 1'b1; pc_value = 32'h400; instruction = enc_i(12'd0, 3'd2, 5'd3, 7'h03);
    rs1_val = 32'h80; rs2_val = 32'd0;
    @(negedge clk);
    enable = 1'b0;
    check("rst_mid_req", system_bus_read_req, 1);
    system_bus_ready = 1'b1;
    @(negedge clk);
    system_bus_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check("rst_mid_rv", result_valid, 0);
    check("rst_mid_noreq", {system_bus_read_req, system_bus_write_req}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    system_bus_read_data_valid = 1'b1;
    system_bus_read_data = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      system_bus_read_data_valid = 1'b0;
      check("late_data_ignored", {result_valid, rd_value_write_enable}, 0);
      check("late_ready", ready, 1);
    end

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 8);
      ins = $urandom; a = $urandom; b = $urandom;
      alt = 1'($urandom_range(0, 1));
      f3 = ins[14:12];
      case (cls)
        0: begin
          ins[6:0] = 7'h33;
          ins[31:25] = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, alt, 5'd0} : 7'd0;
        end
        1: begin
          ins[6:0] = 7'h13;
          if (f3 == 3'd1) ins[31:25] = 7'd0;
          if (f3 == 3'd5) ins[31:25] = {1'b0, alt, 5'd0};
        end
        2: ins[6:0] = 7'h37;
        3: ins[6:0] = 7'h17;
        4: ins[6:0] = 7'h6F;
        5: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; end
        6: begin
          ins[6:0] = 7'h63;
          ins[14:12] = br_f3[$urandom_range(0, 5)];
          if ($urandom_range(0, 2) == 0) b = a;
        end
        7: begin ins[6:0] = 7'h03; ins[14:12] = ld_f3[$urandom_range(0, 4)]; end
        default: begin ins[6:0] = 7'h23; ins[14:12] = 3'($urandom_range(0, 2)); end
      endcase
      rl = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 2);
      run_instr($urandom & 32'hFFFF_FFFC, ins, a, b, $urandom_range(0, 3), rl, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/execute_mem_ctrl.md
EXECUTE_MEM_CTRL -- requirements
Module: execute_mem_ctrl

Interface
REQ-001 SHALL have parameter BUS_ADDR_WIDTH, default 30; word-address width of the system bus.
REQ-002 SHALL have parameter READ_TIMEOUT, default 0; maximum cycles waiting for read data, 0 = no timeout.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-004 SHALL have the following handshake and instruction ports:
- enable  in  1  instruction valid
- ready  out  1  able to accept an instruction
- pc_value  in  32  PC of the instruction
- instruction  in  32  RV32I instruction
- register_file_read_data1  in  32  rs1 value
- register_file_read_data2  in  32  rs2 value
REQ-005 SHALL have the following result ports:
- result_valid  out  1  result qualifier, one-cycle pulse
- rd  out  5  destination register
- next_pc  out  32  next PC
- rd_value_write_enable  out  1  write rd
- rd_value_write_data  out  32  rd data
- trap  out  1  misaligned access or bus timeout
REQ-006 SHALL have the following system bus ports:
- system_bus_ready  in  1  bus accepts the request
- system_bus_addr  out  BUS_ADDR_WIDTH  word address
- system_bus_byte_enable  out  4  byte lanes
- system_bus_read_req  out  1  read request
- system_bus_write_req  out  1  write request
- system_bus_write_data  out  32  write data
- system_bus_read_data  in  32  read data
- system_bus_read_data_valid  in  1  read data qualifier

Function
REQ-007 SHALL implement states IDLE, BUS_REQ and READ_WAIT; ready SHALL be 1 only in IDLE.
REQ-008 SHALL accept an instruction on the cycle where enable && ready, and SHALL register all operands on acceptance.
REQ-009 Non-memory opcodes (OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH) SHALL raise result_valid the cycle after acceptance, and the state SHALL remain IDLE.
REQ-010 SHALL use RV32I semantics for non-memory opcodes:
- OP-IMM shifts take shamt = instruction[24:20].
- JAL and JALR write pc+4; JALR target = (rs1+imm) & ~1.
- BRANCH writes no register: rd_value_write_enable = 0.
- Not-taken branches and all other non-jump opcodes give next_pc = pc+4.
REQ-011 Memory address SHALL be rs1 + sign-extended 12-bit offset, modulo 2^32. The bus address SHALL be address[BUS_ADDR_WIDTH+1:2].
REQ-012 Misaligned accesses SHALL produce result_valid the cycle after acceptance with trap=1 and rd_value_write_enable=0, and SHALL issue no bus request:
- LW/SW with address[1:0] != 0
- LH/LHU/SH with address[0] = 1
REQ-013 Aligned loads and stores SHALL enter BUS_REQ and hold read_req or write_req, addr, byte_enable and write_data stable until the cycle in which system_bus_ready = 1.
REQ-014 Store data and byte enables SHALL follow the access size:
- SB: byte_enable = 4'b0001 << address[1:0]; write_data = {4{rs2[7:0]}}
- SH: byte_enable = 4'b0011 << address[1:0]; write_data = {2{rs2[15:0]}}
- SW: byte_enable = 4'hF
REQ-015 A store SHALL complete with result_valid, rd_value_write_enable=0, next_pc=pc+4, on the cycle after the bus accepts it; the state SHALL return to IDLE.
REQ-016 A load SHALL set byte_enable = 4'hF, then move to READ_WAIT after bus acceptance.
REQ-017 In READ_WAIT, result_valid SHALL pulse the cycle after system_bus_read_data_valid. The lane selected by address[1:0] SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word.
REQ-018 system_bus_read_data_valid SHALL be ignored outside READ_WAIT, including on the acceptance cycle.
REQ-019 If READ_TIMEOUT > 0, a counter SHALL clear on entry to READ_WAIT and increment each waiting cycle. On reaching READ_TIMEOUT, the block SHALL complete with trap=1, rd_value_write_enable=0 and next_pc=pc+4; the counter SHALL saturate and never wrap.
REQ-020 A load with rd = x0 SHALL still perform the bus read but SHALL drive rd_value_write_enable = 0.
REQ-021 Writes to x0 by any other opcode SHALL likewise drive rd_value_write_enable = 0.
REQ-022 Read and write requests SHALL never be asserted simultaneously, and at most one bus transaction SHALL be outstanding.
REQ-023 result_valid SHALL be a single-cycle pulse. All result outputs SHALL hold their value until the next result.

Reset
REQ-024 reset_n low SHALL asynchronously force:
- state IDLE, ready=1 (after release), timeout counter 0
- result_valid, trap, rd_value_write_enable, read_req and write_req = 0
- rd, next_pc, rd_value_write_data, addr, byte_enable and write_data = 0
REQ-025 Reset asserted mid-transaction SHALL abandon it without producing a result. Read data arriving after reset release SHALL be ignored.

Verification
REQ-026 ADDI x5,x0,-1 accepted -> next cycle result_valid=1, rd=5, rd_value_write_data=32'hFFFF_FFFF, next_pc=pc+4.
REQ-027 SB with rs1=0x1001, rs2=0xA5, system_bus_ready held low 3 cycles -> write_req held 4 cycles, byte_enable=4'b0010, write_data=32'hA5A5_A5A5, ready=0 throughout, then result with write_enable=0.
REQ-028 LH at address 0x102, read_data=32'h8001_0000 -> rd_value_write_data=32'hFFFF_8001. The same access with LHU -> 32'h0000_8001.
REQ-029 LW at address 0x06 -> trap=1 one cycle after acceptance, no read_req or write_req ever asserted.
REQ-030 With READ_TIMEOUT=4, a load whose read data never arrives -> trap=1 after 4 READ_WAIT cycles; ready=1 the following cycle.
REQ-031 A taken BEQ with offset -8 at pc=0x100 -> next_pc=0xF8, rd_value_write_enable=0. reset_n pulsed during a load's READ_WAIT -> no result_valid, and a late read_data_valid is ignored.
